// File: rtl/down_timer_if.sv
// Load handshake, control and status bundle for down_timer.
// The timer sits on the slave side; the producer/CPU drives the master side.
interface down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             en;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] cout;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load_valid, load_value, en, auto_reload, abort,
    input  load_ready, cout, busy, tc, done
  );

  modport slave (
    input  load_valid, load_value, en, auto_reload, abort,
    output load_ready, cout, busy, tc, done
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes.
// Emits a one-cycle tc pulse per terminal event; done is a level held in DONE.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  down_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cout;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_cout_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;
  logic             w_done_nxt;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cout_nxt   = r_cout;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    w_done_nxt   = r_done;

    unique case (r_state)
      IDLE, DONE: begin
        if (bus.abort) begin
          // Abort beats a simultaneous load; in IDLE this changes nothing.
          w_state_nxt = IDLE;
          w_cout_nxt  = '0;
          w_done_nxt  = 1'b0;
        end else if (bus.load_valid) begin
          w_cout_nxt   = bus.load_value;
          w_reload_nxt = bus.load_value;
          if (bus.load_value == '0) begin
            w_state_nxt = DONE;
            w_tc_nxt    = 1'b1;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RUN;
            w_done_nxt  = 1'b0;
          end
        end
      end

      RUN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
          w_cout_nxt  = '0;
        end else if (bus.en) begin
          if (r_cout > WIDTH'(1)) begin
            w_cout_nxt = r_cout - WIDTH'(1);
          end else if (r_cout == WIDTH'(1)) begin
            w_tc_nxt = 1'b1;
            if (bus.auto_reload) begin
              w_cout_nxt = r_reload;
            end else begin
              w_cout_nxt  = '0;
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cout_nxt  = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cout   <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cout   <= w_cout_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.cout       = r_cout;
  assign bus.tc         = r_tc;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state == RUN);
  assign bus.load_ready = (r_state != RUN);

endmodule

// File: tb/tb_down_timer.sv
// Directed-vector bench for down_timer; expected values are hand-computed.
module tb_down_timer;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  down_timer_if #(.WIDTH(WIDTH)) u_if ();

  down_timer #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int c, input bit b, input bit t, input bit d);
    check({tag, ".cout"}, 32'(u_if.cout), 32'(c));
    check({tag, ".busy"}, 32'(u_if.busy), 32'(b));
    check({tag, ".tc"},   32'(u_if.tc),   32'(t));
    check({tag, ".done"}, 32'(u_if.done), 32'(d));
    check({tag, ".ready"}, 32'(u_if.load_ready), 32'(!b));
  endtask

  task automatic drive(input bit lv, input int val, input bit en, input bit ar, input bit ab);
    u_if.load_valid  = lv;
    u_if.load_value  = WIDTH'(val);
    u_if.en          = en;
    u_if.auto_reload = ar;
    u_if.abort       = ab;
  endtask

  int ar_cout [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
  bit ar_tc   [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  bit gate_en [4]  = '{1, 0, 0, 1};
  int gate_c  [4]  = '{3, 3, 3, 2};

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2;
    check_outs("reset", 0, 0, 0, 0);
    #1 rst = 1'b0;

    // Reset mid-count
    step();
    drive(1, 9, 1, 0, 0);
    step();
    drive(0, 0, 1, 0, 0);
    check_outs("rst_load9", 9, 1, 0, 0);
    step(); step(); step();
    check_outs("rst_run3", 6, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 0, 0);
    #1 rst = 1'b0;
    step();
    check_outs("rst_after", 0, 0, 0, 0);

    // One-shot
    drive(1, 5, 1, 0, 0);
    step();
    drive(0, 0, 1, 0, 0);
    check_outs("os_load", 5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      check_outs($sformatf("os_c%0d", i), i, 1, 0, 0);
    end
    step();
    check_outs("os_term", 0, 0, 1, 1);
    step();
    check_outs("os_after", 0, 0, 0, 1);
    // Abort beats load in DONE
    drive(1, 7, 1, 0, 1);
    step();
    check_outs("done_abort_ld", 0, 0, 0, 0);

    // Auto-reload
    drive(1, 3, 1, 1, 0);
    step();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      check_outs($sformatf("ar_%0d", i), ar_cout[i], 1, ar_tc[i], 0);
      step();
    end
    drive(0, 0, 1, 1, 1);
    step();
    check_outs("ar_abort", 0, 0, 0, 0);

    // Enable gating and backpressure
    drive(1, 4, 1, 0, 0);
    step();
    check_outs("gate_load", 4, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, gate_en[i], 0, 0);
      step();
      check_outs($sformatf("gate_%0d", i), gate_c[i], 1, 0, 0);
    end
    drive(1, 7, 0, 0, 0);
    step();
    check_outs("bp_hold", 2, 1, 0, 0);
    drive(1, 7, 1, 0, 0);
    step();
    check_outs("bp_count", 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    step();
    check_outs("bp_abort", 0, 0, 0, 0);

    // Abort priority
    drive(1, 6, 1, 0, 0);
    step();
    drive(0, 0, 1, 0, 0);
    check_outs("ab_load", 6, 1, 0, 0);
    step(); step();
    check_outs("ab_run2", 4, 1, 0, 0);
    drive(1, 7, 1, 0, 1);
    step();
    check_outs("ab_abort", 0, 0, 0, 0);
    drive(1, 7, 0, 0, 1);
    step();
    check_outs("ab_idle_both", 0, 0, 0, 0);
    drive(1, 7, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_outs("ab_reload7", 7, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    step();
    check_outs("ab_clear", 0, 0, 0, 0);

    // Zero load with auto_reload
    drive(1, 0, 1, 1, 0);
    step();
    drive(0, 0, 1, 1, 0);
    check_outs("zero_term", 0, 0, 1, 1);
    step();
    check_outs("zero_after1", 0, 0, 0, 1);
    step();
    check_outs("zero_after2", 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
